// File: rtl/dsd_pkg.sv
// Shared definitions for the bit-serial datapath units.
// Contents:
//   state_e   - handshake FSM encoding (IDLE / RUN / DONE)
//   DSD_W     - default operand width
//   cnt_width - bit-counter width for a given operand width (never below 1)
package dsd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int unsigned DSD_W = 32'd4;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 32'd1) ? $clog2(w) : 32'd1;
    endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// Gate-level subtractor cells, mirroring the half/full adder pair of the
// ripple adders.
// half_subtractor: x, y -> d = x - y (difference bit), b = borrow
// full_subtractor: x, y, bin -> d = x - y - bin, bout = borrow out
//   Two half cells plus an OR of their borrows:
//   bout = (~x & y) | (~(x ^ y) & bin)

module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);
    assign d = x ^ y;
    assign b = ~x & y;
endmodule

module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1_s;
    logic b1_s;
    logic b2_s;

    half_subtractor u_hs_xy (
        .x (x),
        .y (y),
        .d (d1_s),
        .b (b1_s)
    );

    half_subtractor u_hs_bin (
        .x (d1_s),
        .y (bin),
        .d (d),
        .b (b2_s)
    );

    assign bout = b1_s | b2_s;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: diff = a - b (mod 2^W), LSB first, one bit
// per clock through a single full-subtractor cell and a borrow flop.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   start      - request, accepted only in IDLE or DONE
//   a, b       - minuend / subtrahend, captured on the accepting edge
//   busy       - high while the bit loop runs
//   done       - one-cycle pulse, diff/borrow_out just updated
//   diff       - result, held until the next completion
//   borrow_out - final borrow, 1 when a < b (unsigned)
module serial_subtractor
    import dsd_pkg::*;
#(
    parameter int unsigned W = DSD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out
);

    localparam int unsigned   CW       = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    state_e        state_q, state_d;
    // Minuend bits leave at the LSB while result bits enter at the MSB, so
    // after W shifts this register holds the finished difference.
    logic [W-1:0]  ar_sh_q, ar_sh_d;
    logic [W-1:0]  b_sh_q,  b_sh_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          brw_q,   brw_d;
    logic [W-1:0]  diff_q,  diff_d;
    logic          bo_q,    bo_d;

    logic          cell_d_s;
    logic          cell_bout_s;

    full_subtractor u_cell (
        .x    (ar_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (brw_q),
        .d    (cell_d_s),
        .bout (cell_bout_s)
    );

    // Next-state and datapath update for the handshake FSM.
    always_comb begin
        state_d = state_q;
        ar_sh_d = ar_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bo_d    = bo_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    ar_sh_d = a;
                    b_sh_d  = b;
                    cnt_d   = '0;
                    brw_d   = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                ar_sh_d = {cell_d_s, ar_sh_q[W-1:1]};
                b_sh_d  = {1'b0, b_sh_q[W-1:1]};
                brw_d   = cell_bout_s;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    diff_d  = {cell_d_s, ar_sh_q[W-1:1]};
                    bo_d    = cell_bout_s;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, counter, borrow and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ar_sh_q <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_sh_q <= ar_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
        end
    end

    // busy/done are pure decodes of the state flops, so they are glitch-free
    // and mutually exclusive.
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bo_q;

endmodule
